// File: rtl/mem_responder.sv
// Wait-state memory responder for the shared instruction/data port.
// One access at a time: accept, count WAIT_STATES cycles, then a single-cycle ready pulse.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_STATES = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic [31:0]      mem [DEPTH_WORDS];

   logic             lat_we;
   logic             lat_err;
   logic [IDX_W-1:0] lat_idx;
   logic [3:0]       lat_be;
   logic [31:0]      lat_wdata;

   logic [IDX_W-1:0] req_idx_c;
   logic             req_err_c;
   logic             go_resp_c;
   logic             sel_we_c;
   logic             sel_err_c;
   logic [IDX_W-1:0] sel_idx_c;

   assign req_idx_c = addr[IDX_W+1:2];
   assign req_err_c = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));

   // Attributes of the access that enters RESP this edge: live inputs when
   // coming straight from IDLE (zero wait states), latched copies otherwise.
   always_comb begin
      go_resp_c = 1'b0;
      sel_we_c  = lat_we;
      sel_err_c = lat_err;
      sel_idx_c = lat_idx;
      if (state == S_IDLE) begin
         go_resp_c = req && (WAIT_STATES == 0);
         sel_we_c  = we;
         sel_err_c = req_err_c;
         sel_idx_c = req_idx_c;
      end else if (state == S_WAIT) begin
         go_resp_c = (cnt == 4'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= 32'd0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         if (go_resp_c) begin
            ready <= 1'b1;
            err   <= sel_err_c;
            if (!sel_we_c && !sel_err_c) begin
               rdata <= mem[sel_idx_c];
            end
         end
         case (state)
            S_IDLE: begin
               if (req) begin
                  state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                  cnt   <= CNT_LOAD;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Request capture; fields are only consumed after an accept, so no reset needed.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && req) begin
         lat_we    <= we;
         lat_err   <= req_err_c;
         lat_idx   <= req_idx_c;
         lat_be    <= be;
         lat_wdata <= wdata;
      end
   end

   // Write commits at the end of RESP unless reset abandons the access.
   always_ff @(posedge clk) begin
      if (!reset && state == S_RESP && lat_we && !lat_err) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) begin
               mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, hand-built multi-cycle sequences,
// and random traffic checked against a word-array model; WAIT_STATES=2 and 0 builds.
module tb_mem_responder;

   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic [31:0] rdata;
   logic        ready, err;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0;
   logic [3:0]  be0 = '0;
   logic [31:0] rdata0;
   logic        ready0, err0;

   int total = 0;
   int bad   = 0;

   logic [31:0] mmem [DEPTH];
   logic [31:0] m_rdata;

   typedef logic [31:0] w4_t [4];

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [3:0]  b;
      logic [31:0] d;
      bit          e;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl [14];

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be),
      .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
   );

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .be(be0),
      .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit r, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      if (sel) begin
         req0 = r; we0 = w; addr0 = a; be0 = b; wdata0 = d;
      end else begin
         req = r; we = w; addr = a; be = b; wdata = d;
      end
   endtask

   function automatic logic rdy_of(input bit sel);
      return sel ? ready0 : ready;
   endfunction

   function automatic logic err_of(input bit sel);
      return sel ? err0 : err;
   endfunction

   function automatic logic [31:0] rd_of(input bit sel);
      return sel ? rdata0 : rdata;
   endfunction

   function automatic bit ref_err(input logic [31:0] a);
      return (a % 4 != 0) || ((a / 4) >= DEPTH);
   endfunction

   // Model effect of one completed access on the word array and held read data.
   task automatic model_apply(input bit w, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d);
      int idx;
      if (ref_err(a)) return;
      idx = int'(a / 4);
      if (w) begin
         for (int i = 0; i < 4; i++)
            if (b[i]) mmem[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
         m_rdata = mmem[idx];
      end
   endtask

   // One handshake: raise req in IDLE, wait (bounded) for ready, drop req, settle to IDLE.
   task automatic access(input bit sel, input bit w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output logic [31:0] rd, output logic e,
                         output int lat);
      bit seen = 0;
      rd  = '0;
      e   = 1'b0;
      lat = -1;
      @(negedge clk);
      drive(sel, 1'b1, w, a, b, d);
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (rdy_of(sel)) begin
            seen = 1;
            lat  = k;
            rd   = rd_of(sel);
            e    = err_of(sel);
         end
      end
      drive(sel, 1'b0, 1'b0, '0, '0, '0);
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL access_timeout: got no ready want ready within 20 cycles");
      end
      @(posedge clk);
      #1;
      chk("ready_single_cycle", 32'(rdy_of(sel)), 32'd0);
   endtask

   task automatic exec_model(input string name, input bit w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d);
      logic [31:0] rd;
      logic        e;
      int          lat;
      access(1'b0, w, a, b, d, rd, e, lat);
      model_apply(w, a, b, d);
      chk({name, "_lat"}, 32'(lat), 32'd3);
      chk({name, "_err"}, 32'(e), 32'(ref_err(a)));
      chk({name, "_rdata"}, rd, m_rdata);
   endtask

   // Hold req continuously across n reads; ready must recur exactly every gap cycles.
   task automatic b2b(input string name, input bit sel, input w4_t addrs, input w4_t exp,
                      input int gap);
      int cnt  = 0;
      int last = 0;
      @(negedge clk);
      drive(sel, 1'b1, 1'b0, addrs[0], 4'hF, '0);
      for (int cyc = 1; cyc <= 60 && cnt < 4; cyc++) begin
         @(posedge clk);
         #1;
         if (rdy_of(sel)) begin
            chk({name, "_rdata"}, rd_of(sel), exp[cnt]);
            chk({name, "_err"}, 32'(err_of(sel)), 32'd0);
            chk({name, "_spacing"}, 32'(cyc - last), 32'((cnt == 0) ? gap - 1 : gap));
            last = cyc;
            cnt++;
            if (cnt < 4) drive(sel, 1'b1, 1'b0, addrs[cnt], 4'hF, '0);
            else         drive(sel, 1'b0, 1'b0, '0, '0, '0);
         end
      end
      drive(sel, 1'b0, 1'b0, '0, '0, '0);
      if (cnt < 4) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d ready pulses want 4", name, cnt);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd, old;
      logic        e;
      int          lat;
      bit          seen;
      logic [31:0] a;
      int          r;

      tbl[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
      tbl[1]  = '{1'b1, 32'h0000_0008, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      tbl[2]  = '{1'b0, 32'h0000_0008, 4'h0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      tbl[3]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF};
      tbl[4]  = '{1'b1, 32'h0000_0010, 4'h5, 32'hAABB_CCDD, 1'b0, 32'hDEAD_BEEF};
      tbl[5]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b0, 32'h11BB_33DD};
      tbl[6]  = '{1'b0, 32'h0000_0006, 4'h0, 32'h0000_0000, 1'b1, 32'h11BB_33DD};
      tbl[7]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h11BB_33DD};
      tbl[8]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
      tbl[9]  = '{1'b1, 32'h0000_0008, 4'h0, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
      tbl[10] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      tbl[11] = '{1'b1, 32'h0000_000A, 4'hF, 32'h0BAD_0BAD, 1'b1, 32'hDEAD_BEEF};
      tbl[12] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
      tbl[13] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

      for (int i = 0; i < int'(DEPTH); i++) mmem[i] = '0;
      m_rdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset_ready", 32'(ready), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_ready_ws0", 32'(ready0), 32'd0);
      chk("reset_rdata_ws0", rdata0, 32'd0);

      // Directed table: basic write/read, byte lanes, error cases, be=0000 write
      for (int i = 0; i < 14; i++) begin
         access(1'b0, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, rd, e, lat);
         model_apply(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d);
         chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd3);
         chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      end

      // Fill every word so later reads have defined expectations
      for (int i = 0; i < int'(DEPTH); i++)
         exec_model("preload", 1'b1, 32'(i * 4), 4'hF, $urandom);

      b2b("b2b_ws2", 1'b0, '{32'h0, 32'h4, 32'h8, 32'hC}, '{mmem[0], mmem[1], mmem[2], mmem[3]}, 4);
      m_rdata = mmem[3];

      // Reset sampled on the edge that would start RESP: no pulse, no write
      old = mmem[8];
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h1234_5678);
      @(posedge clk); #1;
      chk("rst_mid_wait1_ready", 32'(ready), 32'd0);
      @(posedge clk); #1;
      chk("rst_mid_wait2_ready", 32'(ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_ready", 32'(ready), 32'd0);
      chk("rst_mid_err", 32'(err), 32'd0);
      chk("rst_mid_rdata", rdata, 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      reset = 1'b0;
      m_rdata = '0;
      exec_model("rst_mid_readback", 1'b0, 32'h20, 4'h0, '0);
      chk("rst_mid_old_value", m_rdata, old);

      // Reset during the RESP cycle itself must also suppress the write
      old  = mmem[9];
      seen = 0;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h24, 4'hF, ~old);
      for (int k = 1; k <= 10 && !seen; k++) begin
         @(posedge clk); #1;
         if (ready) seen = 1;
      end
      chk("rst_resp_seen", 32'(seen), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_resp_ready", 32'(ready), 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      reset = 1'b0;
      m_rdata = '0;
      exec_model("rst_resp_readback", 1'b0, 32'h24, 4'h0, '0);
      chk("rst_resp_old_value", m_rdata, old);

      // Random traffic against the model
      for (int n = 0; n < 80; n++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
         else if (r == 1) a = 32'($urandom_range(DEPTH, 4000)) << 2;
         else             a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         exec_model("rand", 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
      end

      // Zero-wait-state build
      access(1'b1, 1'b1, 32'h0, 4'hF, 32'hA5A5_5A5A, rd, e, lat);
      chk("ws0_wr0_lat", 32'(lat), 32'd1);
      chk("ws0_wr0_err", 32'(e), 32'd0);
      access(1'b1, 1'b1, 32'h4, 4'hF, 32'h0F0F_1234, rd, e, lat);
      chk("ws0_wr1_lat", 32'(lat), 32'd1);
      access(1'b1, 1'b0, 32'h4, 4'h0, '0, rd, e, lat);
      chk("ws0_rd_lat", 32'(lat), 32'd1);
      chk("ws0_rd_rdata", rd, 32'h0F0F_1234);
      access(1'b1, 1'b0, 32'h2, 4'h0, '0, rd, e, lat);
      chk("ws0_misaligned_err", 32'(e), 32'd1);
      chk("ws0_misaligned_rdata", rd, 32'h0F0F_1234);
      b2b("b2b_ws0", 1'b1, '{32'h0, 32'h4, 32'h0, 32'h4},
          '{32'hA5A5_5A5A, 32'h0F0F_1234, 32'hA5A5_5A5A, 32'h0F0F_1234}, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
